// File: rtl/multdiv_unit_if.sv
// ---------------------------------------------------------------------------
// multdiv_unit_if
//   Operand / control / result bundle between the execute stage and the
//   iterative multiply/divide unit.
//
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start-multiply pulse
//   ctrl_DIV        start-divide pulse
//   data_result     product low word / quotient
//   data_exception  overflow or divide-by-zero flag
//   data_resultRDY  one-cycle completion strobe
//   data_busy       operation in flight
//
//   master: the pipeline side (drives operands and start pulses)
//   slave : the multiply/divide unit
// ---------------------------------------------------------------------------
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             data_busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, data_busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, data_busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// ---------------------------------------------------------------------------
// multdiv_unit
//   Iterative signed WIDTH-bit multiply / divide unit. A start pulse latches
//   the operands; WIDTH iterations of shift-add (multiply) or restoring
//   division follow, then one sign-correction cycle, then a one-cycle
//   data_resultRDY strobe. Latency is WIDTH+1 edges after the start edge.
//
// Ports
//   clock         system clock, all state on the rising edge
//   ctrl_reset_n  asynchronous active-low reset
//   bus (slave)   operands, start pulses, result/exception/RDY/busy
// ---------------------------------------------------------------------------
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clock,
    input  logic           ctrl_reset_n,
    multdiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // operand signs differ
    logic [WIDTH-1:0]   m_q, m_d;            // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q, acc_d;        // product, or {remainder, quotient}
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic               start;
    logic               start_div;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo;

    always_comb begin
        start     = bus.ctrl_MULT | bus.ctrl_DIV;
        start_div = ~bus.ctrl_MULT;          // MULT wins when both pulse
        abs_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        abs_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

        // Shift-add: multiplier sits in the low half and is consumed LSB first;
        // the carry out of the high-half add is shifted back in from the top.
        mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring division: shift {rem, quo} left, trial-subtract divisor,
        // keep the difference and set the quotient bit if it did not borrow.
        div_shift = acc_q << 1;
        div_trial = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, m_q};
        div_next  = div_trial[WIDTH] ? div_shift
                                     : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

        prod_signed = neg_q ? -acc_q : acc_q;
        quo         = acc_q[WIDTH-1:0];

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        m_d      = m_q;
        acc_d    = acc_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            // Accepted in every state; anything in flight is abandoned.
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = start_div;
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            m_d      = start_div ? abs_b : abs_a;
            acc_d    = {{WIDTH{1'b0}}, (start_div ? abs_a : abs_b)};
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (!is_div_q) begin
                        result_d = prod_signed[WIDTH-1:0];
                        // Fits iff the top WIDTH+1 bits are a pure sign extension.
                        exc_d    = !((&prod_signed[2*WIDTH-1:WIDTH-1]) ||
                                     (~|prod_signed[2*WIDTH-1:WIDTH-1]));
                    end else if (m_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (!neg_q && quo[WIDTH-1]) begin
                        // Only most-negative / -1 reaches a positive 2**(WIDTH-1).
                        result_d = quo;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quo : quo;
                        exc_d    = 1'b0;
                    end
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_busy      = (state_q == RUN) || (state_q == FIX);
endmodule

// File: tb/tb_multdiv_unit.sv
// ---------------------------------------------------------------------------
// tb_multdiv_unit
//   Directed bench for multdiv_unit: reset state, signed multiply and divide
//   results, exceptions, constant latency, restart while busy and reset in
//   the middle of an operation. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_multdiv_unit;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 33;

    logic clock = 1'b0;
    logic ctrl_reset_n;
    int   checks = 0;
    int   errors = 0;

    multdiv_unit_if #(.WIDTH(WIDTH)) bus ();

    multdiv_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus)
    );

    always #5 clock = ~clock;

    // Drive a start pulse so that exactly one rising edge (E0) samples it.
    // Returns at the falling edge after E0 with operands scrambled.
    task automatic pulse(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Count falling edges until RDY; lat=-1 if it never comes. busy_gap notes
    // any cycle before RDY where busy dropped.
    task automatic wait_rdy(output int lat, output bit busy_gap);
        lat      = -1;
        busy_gap = 1'b0;
        for (int k = 1; k <= LATENCY + 8; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                return;
            end
            if (bus.data_busy !== 1'b1) busy_gap = 1'b1;
        end
    endtask

    task automatic run_op(input string name, input bit mul, input bit div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input bit exp_e);
        int lat;
        bit gap;
        pulse(mul, div, a, b);
        checks++;
        if (bus.data_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, bus.data_busy);
        end
        wait_rdy(lat, gap);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LATENCY);
        end
        checks++;
        if (gap !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_gap: got %b expected 0", name, gap);
        end
        checks++;
        if (bus.data_result !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, bus.data_result, exp_r);
        end
        checks++;
        if (bus.data_exception !== exp_e) begin
            errors++;
            $display("FAIL %s exception: got %b expected %b", name, bus.data_exception, exp_e);
        end
        checks++;
        if (bus.data_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b expected 0", name, bus.data_busy);
        end
        @(negedge clock);
        checks++;
        if (bus.data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL %s rdy_one_cycle: got %b expected 0", name, bus.data_resultRDY);
        end
        checks++;
        if (bus.data_result !== exp_r) begin
            errors++;
            $display("FAIL %s result_hold: got %h expected %h", name, bus.data_result, exp_r);
        end
        $display("op %-14s A=%h B=%h -> result=%h exc=%b lat=%0d", name, a, b,
                 bus.data_result, bus.data_exception, lat);
    endtask

    task automatic test_reset;
        ctrl_reset_n      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.data_result !== 32'h0) begin
            errors++; $display("FAIL reset_result: got %h expected 0", bus.data_result);
        end
        checks++;
        if (bus.data_exception !== 1'b0) begin
            errors++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception);
        end
        checks++;
        if (bus.data_resultRDY !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY);
        end
        checks++;
        if (bus.data_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus.data_busy);
        end
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        $display("reset: outputs idle");
    endtask

    task automatic test_mult;
        run_op("mul_7x-6",   1, 0, 32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        run_op("mul_ovf",    1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_minx1",  1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0);
        run_op("mul_maxx2",  1, 0, 32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1);
        run_op("mul_both",   1, 1, 32'd6,        32'd3,        32'd18,        1'b0);
    endtask

    task automatic test_div;
        run_op("div_-100/7", 0, 1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 1'b0);
        run_op("div_100/-7", 0, 1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        run_op("div_-100/-7",0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0);
        run_op("div_5/0",    0, 1, 32'd5,        32'd0,        32'h0000_0000, 1'b1);
        run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    endtask

    task automatic test_back_to_back;
        int lat;
        bit gap;
        int early;
        early = 0;
        pulse(1, 0, 32'd3, 32'd3);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) early++;
            if (bus.data_busy !== 1'b1) gap = 1'b1;
        end
        pulse(0, 1, 32'd9, 32'd3);
        checks++;
        if (bus.data_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy_restart: got %b expected 1", bus.data_busy);
        end
        wait_rdy(lat, gap);
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL b2b_early_rdy: got %0d expected 0", early);
        end
        checks++;
        if (lat !== LATENCY) begin
            errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LATENCY);
        end
        checks++;
        if (gap !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_gap: got %b expected 0", gap);
        end
        checks++;
        if (bus.data_result !== 32'd3) begin
            errors++; $display("FAIL b2b_result: got %h expected 00000003", bus.data_result);
        end
        checks++;
        if (bus.data_exception !== 1'b0) begin
            errors++; $display("FAIL b2b_exc: got %b expected 0", bus.data_exception);
        end
        early = 0;
        for (int k = 0; k < LATENCY + 5; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL b2b_extra_rdy: got %0d expected 0", early);
        end
        $display("b2b: MULT 3*3 aborted by DIV 9/3 -> result=%h lat=%0d", bus.data_result, lat);
    endtask

    task automatic test_reset_midop;
        int rdys;
        // Leave nonzero result and exception so the reset clear is visible.
        run_op("pre_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        pulse(1, 0, 32'd3, 32'd5);
        repeat (11) @(negedge clock);
        ctrl_reset_n = 1'b0;
        #1;
        checks++;
        if (bus.data_result !== 32'h0) begin
            errors++; $display("FAIL midrst_result: got %h expected 0", bus.data_result);
        end
        checks++;
        if (bus.data_exception !== 1'b0) begin
            errors++; $display("FAIL midrst_exc: got %b expected 0", bus.data_exception);
        end
        checks++;
        if (bus.data_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_busy: got %b expected 0", bus.data_busy);
        end
        checks++;
        if (bus.data_resultRDY !== 1'b0) begin
            errors++; $display("FAIL midrst_rdy: got %b expected 0", bus.data_resultRDY);
        end
        repeat (2) @(negedge clock);
        ctrl_reset_n = 1'b1;
        rdys = 0;
        for (int k = 0; k < LATENCY + 5; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) rdys++;
        end
        checks++;
        if (rdys !== 0) begin
            errors++; $display("FAIL midrst_stray_rdy: got %0d expected 0", rdys);
        end
        $display("midrst: reset during MULT cleared outputs, stray rdy=%0d", rdys);
        run_op("post_7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
